// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin arbiter sharing one cordic_top between NREQ requesters.
//   clk            : single clock, rising edge
//   rst            : asynchronous, active-low reset
//   req_valid/req_angle/req_ready : per-requester IEEE-754 angle handshake
//   rsp_valid/rsp_cos/rsp_sin/rsp_timeout : one-hot result strobe plus held Q15 result
//   cord_valid_in/cord_angle/cord_cos/cord_sin/cord_valid : cordic_top connection
//   busy           : high whenever a transaction is in flight
module cordic_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_angle,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_cos,
    output logic [15:0]          rsp_sin,
    output logic                 rsp_timeout,
    output logic                 cord_valid_in,
    output logic [31:0]          cord_angle,
    input  logic [15:0]          cord_cos,
    input  logic [15:0]          cord_sin,
    input  logic                 cord_valid,
    output logic                 busy
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, owner_q, owner_d, gnt, idx;
    logic            found;
    logic [7:0]      cnt_q, cnt_d;
    logic [31:0]     angle_q, angle_d;
    logic [15:0]     cos_q, cos_d, sin_q, sin_d;
    logic            to_q, to_d;

    // Scan downward so the requester closest after ptr overwrites the others.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IW'((int'(ptr_q) + i) % NREQ);
            if (req_valid[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        angle_d = angle_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        to_d    = to_q;
        case (state_q)
            IDLE: if (found) begin
                owner_d = gnt;
                angle_d = req_angle[{gnt, 5'd0} +: 32];
                state_d = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            // A result arriving on the final count still wins over the abort.
            WAIT: if (cord_valid) begin
                cos_d   = cord_cos;
                sin_d   = cord_sin;
                to_d    = 1'b0;
                state_d = RESP;
            end else if (cnt_q == 8'(TIMEOUT)) begin
                cos_d   = '0;
                sin_d   = '0;
                to_d    = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            RESP: begin
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            angle_q <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            angle_q <= angle_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            to_q    <= to_d;
        end
    end

    // req_ready is combinational from req_valid, so it is gated by reset explicitly.
    assign req_ready     = (rst && state_q == IDLE && found) ? NREQ'(1) << gnt : '0;
    assign rsp_valid     = (state_q == RESP) ? NREQ'(1) << owner_q : '0;
    assign rsp_cos       = cos_q;
    assign rsp_sin       = sin_q;
    assign rsp_timeout   = to_q;
    assign cord_valid_in = state_q == ISSUE;
    assign cord_angle    = angle_q;
    assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: table, directed and randomized checks of cordic_arbiter.
module tb_cordic_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_angle;
    logic [3:0]   req_ready, rsp_valid;
    logic [15:0]  rsp_cos, rsp_sin, cord_cos, cord_sin;
    logic         rsp_timeout, cord_valid_in, cord_valid, busy;
    logic [31:0]  cord_angle;

    int checks = 0;
    int errors = 0;
    int last   = 3;

    typedef struct {
        logic [3:0]  rv;
        logic [31:0] ang;
        int          k;
        logic [15:0] c;
        logic [15:0] s;
        int          g;
    } vec_t;

    vec_t tbl[8];

    cordic_arbiter #(.NREQ(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_angle(req_angle),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_cos(rsp_cos),
        .rsp_sin(rsp_sin), .rsp_timeout(rsp_timeout), .cord_valid_in(cord_valid_in),
        .cord_angle(cord_angle), .cord_cos(cord_cos), .cord_sin(cord_sin),
        .cord_valid(cord_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [31:0] a);
        return {a ^ 32'h3, a ^ 32'h2, a ^ 32'h1, a};
    endfunction

    // Round-robin rule: first valid requester after the previous owner, wrapping.
    function automatic int next_grant(input int prev, input logic [3:0] rv);
        for (int off = 1; off <= 4; off++)
            if (rv[(prev + off) % 4]) return (prev + off) % 4;
        return -1;
    endfunction

    // Starts at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    // k < 0 means the cordic never answers.
    task automatic run_txn(input logic [3:0] rv, input logic [127:0] ang, input int k,
                           input logic [15:0] c, input logic [15:0] s, input int g,
                           input bit spur, input string tag);
        logic [3:0]  oh;
        logic [15:0] ec, es;
        logic        eto;
        bit          bad;
        int          n;
        oh  = 4'b0001 << g;
        bad = 1'b0;
        ec  = (k < 0) ? 16'h0 : c;
        es  = (k < 0) ? 16'h0 : s;
        eto = (k < 0);
        req_valid = rv;
        req_angle = ang;
        @(negedge clk);
        chk({tag, "_ready"}, req_ready, oh);
        chk({tag, "_idle_busy"}, busy, 0);
        @(posedge clk); #1;
        cord_valid = spur;
        cord_cos   = 16'hDEAD;
        cord_sin   = 16'hBEEF;
        @(negedge clk);
        chk({tag, "_issue"}, cord_valid_in, 1);
        chk({tag, "_angle"}, cord_angle, ang[32*g +: 32]);
        chk({tag, "_ready_off"}, req_ready, 0);
        @(posedge clk); #1;
        cord_valid = 1'b0;
        if (k < 0) begin
            n = 0;
            forever begin
                @(negedge clk);
                if (rsp_valid != 0 || n >= 400) break;
                if (req_ready != 0 || cord_valid_in) bad = 1'b1;
                n++;
                @(posedge clk); #1;
            end
            chk({tag, "_wait_cycles"}, n, 256);
        end else begin
            for (int w = 1; w < k; w++) begin
                @(negedge clk);
                if (rsp_valid != 0 || cord_valid_in || req_ready != 0) bad = 1'b1;
                @(posedge clk); #1;
            end
            cord_valid = 1'b1;
            cord_cos   = c;
            cord_sin   = s;
            @(negedge clk);
            if (rsp_valid != 0) bad = 1'b1;
            @(posedge clk); #1;
            cord_valid = 1'b0;
            cord_cos   = 16'($urandom);
            cord_sin   = 16'($urandom);
            @(negedge clk);
        end
        chk({tag, "_quiet"}, bad, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, oh);
        chk({tag, "_cos"}, rsp_cos, ec);
        chk({tag, "_sin"}, rsp_sin, es);
        chk({tag, "_timeout"}, rsp_timeout, eto);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0]  rv;
        logic [15:0] c, s;
        int          g;
        tbl[0] = '{4'b0001, 32'h3F800000, 3, 16'h4529, 16'h6BB6, 0};
        tbl[1] = '{4'b1111, 32'h40000000, 1, 16'h1111, 16'h2222, 1};
        tbl[2] = '{4'b1111, 32'hBF000000, 2, 16'h3333, 16'h4444, 2};
        tbl[3] = '{4'b1010, 32'h3E800000, 5, 16'h5555, 16'h6666, 3};
        tbl[4] = '{4'b1010, 32'h3F000000, 1, 16'h7777, 16'h8888, 1};
        tbl[5] = '{4'b0100, 32'h40400000, 4, 16'h9999, 16'hAAAA, 2};
        tbl[6] = '{4'b0001, 32'hC0000000, 2, 16'hBBBB, 16'hCCCC, 0};
        tbl[7] = '{4'b1000, 32'h3DCCCCCD, 6, 16'hDDDD, 16'hEEEE, 3};

        rst        = 1'b0;
        req_valid  = 4'b1111;
        req_angle  = pack(32'h12345678);
        cord_valid = 1'b0;
        cord_cos   = '0;
        cord_sin   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cord_valid_in", cord_valid_in, 0);
        chk("rst_cord_angle", cord_angle, 0);
        chk("rst_rsp", {rsp_cos, rsp_sin}, 0);
        chk("rst_timeout", rsp_timeout, 0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].rv, pack(tbl[i].ang), tbl[i].k, tbl[i].c, tbl[i].s, tbl[i].g, 1'b0,
                    $sformatf("tbl%0d", i));
        last = 3;

        req_valid  = '0;
        cord_valid = 1'b1;
        cord_cos   = 16'h0BAD;
        cord_sin   = 16'h0BAD;
        @(negedge clk);
        chk("spur_idle_rsp", rsp_valid, 0);
        chk("spur_idle_busy", busy, 0);
        @(posedge clk); #1;
        cord_valid = 1'b0;
        @(negedge clk);
        chk("spur_idle_hold", {rsp_cos, rsp_sin}, {16'hDDDD, 16'hEEEE});
        chk("spur_idle_busy2", busy, 0);
        @(posedge clk); #1;

        g = next_grant(last, 4'b0001);
        run_txn(4'b0001, pack(32'h3F400000), 3, 16'h1234, 16'h5678, g, 1'b1, "spur_issue");
        last = g;
        g = next_grant(last, 4'b0010);
        run_txn(4'b0010, pack(32'h3F100000), -1, 16'hFFFF, 16'hFFFF, g, 1'b0, "timeout");
        last = g;
        g = next_grant(last, 4'b0100);
        run_txn(4'b0100, pack(32'h3F200000), 256, 16'h2468, 16'h1357, g, 1'b0, "edge_valid");
        last = g;

        for (int i = 0; i < 20; i++) begin
            rv = 4'($urandom_range(1, 15));
            c  = 16'($urandom);
            s  = 16'($urandom);
            g  = next_grant(last, rv);
            run_txn(rv, pack($urandom), int'($urandom_range(1, 6)), c, s, g, 1'b0,
                    $sformatf("rnd%0d", i));
            last = g;
        end

        req_valid = 4'b0001;
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end
        req_valid = '0;
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_angle", cord_angle, 0);
        chk("midrst_rsp", {rsp_cos, rsp_sin}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cord_valid = 1'b1;
        cord_cos   = 16'h7FFF;
        cord_sin   = 16'h7FFF;
        @(negedge clk);
        chk("late_valid_rsp", rsp_valid, 0);
        chk("late_valid_busy", busy, 0);
        @(posedge clk); #1;
        cord_valid = 1'b0;
        @(negedge clk);
        chk("late_valid_hold", {rsp_cos, rsp_sin}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_txn(4'b1111, pack(32'h40490FDB), 1 + i % 3, 16'(i * 3 + 1), 16'(i * 5 + 2), i % 4,
                    1'b0, $sformatf("rr%0d", i));

        req_valid = '0;
        @(negedge clk);
        chk("end_idle", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter NREQ, default 4, meaning number of requesters sharing one cordic_top instance (2..8).
REQ-002 Parameter TIMEOUT, default 255, meaning max WAIT-state count before a transaction is aborted (8-bit counter).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-005 req_valid  input  NREQ  requester i has an angle pending.
REQ-006 req_angle  input  32*NREQ  IEEE-754 angle; requester i at bits [32i+31:32i].
REQ-007 req_ready  output  NREQ  acceptance strobe; transfer when req_valid[i] & req_ready[i].
REQ-008 rsp_valid  output  NREQ  one-hot, one-cycle result strobe to the owning requester.
REQ-009 rsp_cos, rsp_sin  output  16 each  Q15 result, valid with rsp_valid.
REQ-010 rsp_timeout  output  1  qualifies rsp_valid; 1 = result aborted.
REQ-011 cord_valid_in  output  1  drives cordic_top valid_in.
REQ-012 cord_angle  output  32  drives cordic_top angle_ieee754.
REQ-013 cord_cos, cord_sin  input  16 each  from cordic_top cos_q15/sin_q15.
REQ-014 cord_valid  input  1  from cordic_top valid.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight.
REQ-017 IDLE: if any req_valid, grant one requester round-robin, searching from ptr+1 upward with wrap at NREQ-1 -> 0; req_ready[grant]=1 combinationally that cycle, all other req_ready=0; latch angle and owner index; -> ISSUE.
REQ-018 req_ready SHALL be 0 in every state other than IDLE; requesters may drop req_valid before acceptance.
REQ-019 ISSUE: cord_valid_in=1 for exactly this one cycle, cord_angle = latched angle; WAIT counter cleared; -> WAIT.
REQ-020 cord_angle SHALL hold the latched angle from ISSUE until the next accept.
REQ-021 WAIT: counter increments each cycle; cord_valid=1 -> capture cord_cos/cord_sin, rsp_timeout=0, -> RESP.
REQ-022 WAIT with counter==TIMEOUT and cord_valid=0 -> rsp_cos=rsp_sin=0, rsp_timeout=1, -> RESP (abort after TIMEOUT+1 WAIT cycles).
REQ-023 Simultaneous cord_valid and counter==TIMEOUT: valid wins, no timeout.
REQ-024 cord_valid in IDLE, ISSUE or RESP SHALL be ignored (no capture, no state change).
REQ-025 RESP: rsp_valid[owner]=1 for one cycle; ptr <= owner; -> IDLE.
REQ-026 rsp_cos/rsp_sin/rsp_timeout SHALL hold their last value until the next RESP.
REQ-027 Latency: accept at cycle T, cord_valid_in at T+1, cord_valid at T+1+k (k>=1) -> rsp_valid at T+2+k, new accept possible at T+3+k.
REQ-028 Single requester continuously valid SHALL be re-granted each transaction; with all valid, grants cycle 0,1,..,NREQ-1,0.

Reset
REQ-029 rst low SHALL immediately force state IDLE, ptr=NREQ-1 (requester 0 first priority), counter=0, owner=0.
REQ-030 During/after reset all outputs 0: req_ready, rsp_valid, rsp_cos, rsp_sin, rsp_timeout, cord_valid_in, cord_angle, busy.
REQ-031 Reset mid-transaction SHALL abandon it with no rsp_valid; a late cord_valid after reset release is ignored per REQ-024.

Verification
REQ-032 After reset, req_valid=0001, angle 0x3F800000 (1.0 rad), cordic result at k cycles -> req_ready=0001 at T, cord_valid_in at T+1, rsp_valid=0001 at T+2+k with rsp_cos~0x4529, rsp_sin~0x6BB6, rsp_timeout=0.
REQ-033 req_valid=1111 held, 8 transactions -> grant order 0,1,2,3,0,1,2,3; each rsp_valid bit matches its grant.
REQ-034 cord_valid never asserted, TIMEOUT=255 -> rsp_valid at owner exactly 256 WAIT cycles after ISSUE, rsp_cos=rsp_sin=0, rsp_timeout=1.
REQ-035 cord_valid asserted on the cycle counter==TIMEOUT -> captured result, rsp_timeout=0.
REQ-036 rst pulled low in WAIT, cord_valid asserted 2 cycles after release -> no rsp_valid, busy=0, next grant to requester 0.
REQ-037 Spurious cord_valid pulses in IDLE and ISSUE -> no rsp_valid, outputs unchanged.
